// File: rtl/edge_detector_pkg.sv
// Shared constants and helpers for the edge detector and its synchronizer.
// Edge selection values, default synchronizer depth and priming-counter sizing.
package edge_detector_pkg;

  localparam bit EDGE_RISE = 1'b0;
  localparam bit EDGE_FALL = 1'b1;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;

  // Depths outside the supported range are pulled back to the nearest legal value.
  function automatic int clamp_stages(input int stages);
    if (stages < SYNC_STAGES_MIN) begin
      return SYNC_STAGES_MIN;
    end
    if (stages > SYNC_STAGES_MAX) begin
      return SYNC_STAGES_MAX;
    end
    return stages;
  endfunction

  // Priming runs until the chain and prev register hold only post-reset samples.
  function automatic int prime_max(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Reusable on any asynchronous input path feeding the sys_clk domain.
module sync_chain
  import edge_detector_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int DEPTH = clamp_stages(STAGES);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d};
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/edge_detector.sv
// Selected-edge detector on an asynchronous line: synchronizer, prev sample,
// post-reset priming and a registered one-cycle pulse output.
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter bit FALL_EDGE   = EDGE_RISE,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic sig,
  output logic edge_sig
);

  localparam int STAGES  = clamp_stages(SYNC_STAGES);
  localparam int CNT_MAX = prime_max(STAGES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             s;
  logic             prev_q;
  logic             prev_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             edge_q;
  logic             edge_d;
  logic             primed;
  logic             det;

  sync_chain #(
    .STAGES (STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d       (sig),
    .q       (s)
  );

  // Output stays suppressed until every sample in the pipeline postdates reset.
  always_comb begin
    prev_d = s;
    primed = (cnt_q == CNT_W'(CNT_MAX));
    cnt_d  = primed ? cnt_q : cnt_q + CNT_W'(1);
    if (FALL_EDGE == EDGE_FALL) begin
      det = ~s & prev_q;
    end else begin
      det = s & ~prev_q;
    end
    edge_d = det & primed;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      edge_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
    end
  end

  assign edge_sig = edge_q;

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: rising and falling instances share one line,
// expected pulse cycles are queued when sig is driven and checked every cycle.
`timescale 1ns/100ps
module tb_edge_detector;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic sig     = 1'b0;
  logic edge_rise;
  logic edge_fall;

  int cyc_edge   = 0;
  int prime_edge = 0;
  int n_checks   = 0;
  int n_fail     = 0;
  bit done       = 1'b0;
  int q_rise[$];
  int q_fall[$];

  edge_detector #(
    .FALL_EDGE   (1'b0),
    .SYNC_STAGES (2)
  ) u_rise (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .sig      (sig),
    .edge_sig (edge_rise)
  );

  edge_detector #(
    .FALL_EDGE   (1'b1),
    .SYNC_STAGES (2)
  ) u_fall (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .sig      (sig),
    .edge_sig (edge_fall)
  );

  always #41.5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc_edge <= cyc_edge + 1;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc_edge, obs, exp);
    end
  endtask

  // A change captured at edge k pulses after edge k+2, unless k is still inside priming.
  task automatic drive_sig(input logic v);
    int k;
    if (v !== sig) begin
      k = cyc_edge + 1;
      if (rst === 1'b1 && k >= prime_edge + 1) begin
        if (v) q_rise.push_back(k + 2);
        else   q_fall.push_back(k + 2);
      end
      $display("drive sig=%b captured at edge %0d", v, k);
      sig = v;
    end
  endtask

  task automatic do_reset(input real low_ns);
    rst = 1'b0;
    q_rise.delete();
    q_fall.delete();
    #0.5;
    check("reset_rise_out", edge_rise, 1'b0);
    check("reset_fall_out", edge_fall, 1'b0);
    #(low_ns - 0.5);
    rst = 1'b1;
    prime_edge = cyc_edge + 1;
    $display("reset released, first edge %0d", prime_edge);
  endtask

  task automatic at_phase(input int n);
    repeat (n) @(posedge sys_clk);
    #30;
  endtask

  task automatic monitor_cycle();
    logic exp_r;
    logic exp_f;
    @(posedge sys_clk);
    #20;
    exp_r = (q_rise.size() > 0 && q_rise[0] == cyc_edge);
    exp_f = (q_fall.size() > 0 && q_fall[0] == cyc_edge);
    if (exp_r) void'(q_rise.pop_front());
    if (exp_f) void'(q_fall.pop_front());
    check("rise_pulse", edge_rise, exp_r);
    check("fall_pulse", edge_fall, exp_f);
    if (exp_r || exp_f)
      $display("cycle %0d: rise=%b fall=%b (expected %b/%b)", cyc_edge, edge_rise, edge_fall, exp_r, exp_f);
  endtask

  initial begin
    #10;
    do_reset(5.0);
    fork
      begin
        while (!done) monitor_cycle();
      end
      begin
        // Rise then fall near 1 us.
        at_phase(12);
        drive_sig(1'b1);
        at_phase(3);
        drive_sig(1'b0);
        at_phase(6);

        // Reset while the line is held high, then drop it.
        drive_sig(1'b1);
        at_phase(6);
        do_reset(1.0);
        at_phase(6);
        drive_sig(1'b0);
        at_phase(6);

        // Reset while a rise is still inside the synchronizer.
        drive_sig(1'b1);
        at_phase(1);
        do_reset(5.0);
        at_phase(6);
        drive_sig(1'b0);
        at_phase(6);

        // Reset while edge_sig is high.
        drive_sig(1'b1);
        at_phase(3);
        check("pulse_before_reset", edge_rise, 1'b1);
        do_reset(3.0);
        at_phase(6);
        drive_sig(1'b0);
        at_phase(6);

        // 20 ns glitches wholly between clock edges are never sampled.
        sig = 1'b1;
        #20;
        sig = 1'b0;
        at_phase(6);
        drive_sig(1'b1);
        at_phase(6);
        sig = 1'b0;
        #20;
        sig = 1'b1;
        at_phase(6);
        drive_sig(1'b0);
        at_phase(6);

        // 20 toggles every 349 ns, reset pulsed shortly before toggles 7 and 15.
        at_phase(1);
        #20;
        for (int i = 0; i < 20; i++) begin
          if (i > 0) begin
            if (i == 6 || i == 14) begin
              #289;
              do_reset(1.0);
              #59;
            end else begin
              #349;
            end
          end
          drive_sig(~sig);
        end
        at_phase(8);
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
